db_req_arb: RTL and testbench
=============================

Name: db_req_arb

Overview:
- Multi-channel request front-end for the key/value DB controller.
- Accepts key lookups from NUM_CH independent network-side streams and arbitrates them round-robin.
- Computes a fold hash per key and issues one registered request per cycle to the DB controller.
- Tracks outstanding requests in order and routes each in-order DB response back to the originating channel.

Parameters:
NUM_CH, 2, number of input channels (1..8)
KEY_SIZE, 96, key width in bits (tuple: src IP, dst IP, dst UDP port, reserved)
FLAG_SIZE, 4, op/flag width
HASH_SIZE, 32, hash width
MAX_OUTSTANDING, 4, depth of the in-flight order FIFO (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  NUM_CH  per-channel request valid
in_ready  out  NUM_CH  per-channel accept
in_key  in  NUM_CH*KEY_SIZE  per-channel key; channel i occupies bits [i*KEY_SIZE +: KEY_SIZE]
in_flag  in  NUM_CH*FLAG_SIZE  per-channel op, same packing
db_req_valid  out  1  request to DB controller
db_req_ready  in  1  DB controller accepts request
db_req_hash  out  HASH_SIZE  folded hash of key
db_req_key  out  KEY_SIZE  key
db_req_op  out  FLAG_SIZE  op
db_rsp_valid  in  1  DB response, one-cycle pulse, in request order
db_rsp_flag  in  FLAG_SIZE  response status (1 SUSPECTION, 2 ARREST, 3 FILTERED, 4 EXPIRED)
out_valid  out  NUM_CH  per-channel response pulse
out_flag  out  NUM_CH*FLAG_SIZE  per-channel response flag
err_unexp  out  1  sticky: response received with nothing outstanding

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, order FIFO empty, RR pointer = NUM_CH-1 so channel 0 has first priority; in_ready=0 while rst is high.
- Hash: key is zero-padded to a multiple of HASH_SIZE, split into HASH_SIZE-bit words, all words XORed. Purely combinational on the accepted key.
- Arbitration: grant = first channel with in_valid set, searching from RR pointer+1 modulo NUM_CH.
- in_ready[g] = 1 only for the granted channel, and only when can_accept. All other channels read 0.
- can_accept = (output register empty OR db_req_ready) AND order FIFO count < MAX_OUTSTANDING.
- FIFO count is evaluated before any same-cycle pop. When the FIFO is full and a response arrives in the same cycle, that cycle does not accept.
- Accept (in_valid[g] & in_ready[g]):
  - Next cycle, db_req_valid=1 with key/hash/op registered.
  - Channel id g is pushed into the order FIFO.
  - RR pointer := g.
  - Latency from input accept to db_req_valid is 1 cycle.
- Request output: db_req_* is held stable while db_req_valid & !db_req_ready. When db_req_ready=1 and a new accept occurs in the same cycle, the register reloads, giving full throughput of 1 request/clk. When db_req_ready=1 and there is no accept, db_req_valid drops to 0.
- Response path: db_rsp_valid pops the FIFO head ch.
  - Next cycle, out_valid[ch]=1 for exactly 1 cycle with out_flag[ch] = db_rsp_flag.
  - Other out_valid bits are 0. out_flag slices hold their last value.
  - Response latency is 1 cycle.
- Empty FIFO + db_rsp_valid: response is dropped, no out_valid, err_unexp := 1 until rst.
- Simultaneous push and pop: both take effect and the count is unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING.
- A response may return for a request whose db_req handshake completed in the same cycle. The FIFO push precedes the request handshake, so the entry is already present.
- Reset mid-operation: in-flight requests are abandoned and the FIFO is cleared. Responses arriving afterwards raise err_unexp.

Optional Feature:
DB_REQ_STATS_EN
- Defined: adds output ports stat_req (NUM_CH*32) and stat_rsp (NUM_CH*32).
  - These are per-channel counters of accepted requests and delivered responses.
  - Incremented in the cycle after the event, wrap at 2^32, cleared by rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single channel, NUM_CH=2: ch0 key=0x111111112222222244444444, flag=1, db_req_ready=1 -> db_req_valid next cycle, hash=0x77777777, op=1. Then db_rsp_valid with flag=3 -> out_valid=2'b01, out_flag[3:0]=3 one cycle later.
- Fairness: both channels valid continuously, db_req_ready=1, responses echoed -> grants alternate 0,1,0,1. Exactly 1 request/clk. Each out_valid maps to the correct channel in order.
- Backpressure: db_req_ready=0 for 5 cycles -> db_req_* stable, no further accepts (register full). Release -> resumes with no loss or duplication.
- FIFO full: 4 requests issued, no responses -> all in_ready=0. Response and new request in the same cycle -> no accept that cycle, accept on the next.
- Unexpected response: db_rsp_valid with FIFO empty -> no out_valid, err_unexp=1 and stays 1; rst clears it.
- Reset mid-flight: 2 outstanding, assert rst 1 cycle -> all outputs 0, ch0 granted first afterwards. With DB_REQ_STATS_EN, counters read 0.

Source files
------------

// File: rtl/db_req_arb_if.sv
// Bus bundle for db_req_arb: network-side request streams, the DB
// controller request/response channels and per-channel response outputs.
// The slave modport is the arbiter's view; master is the environment's.
interface db_req_arb_if #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned KEY_SIZE  = 96,
  parameter int unsigned FLAG_SIZE = 4,
  parameter int unsigned HASH_SIZE = 32
);

  logic [NUM_CH-1:0]           in_valid;
  logic [NUM_CH-1:0]           in_ready;
  logic [NUM_CH*KEY_SIZE-1:0]  in_key;
  logic [NUM_CH*FLAG_SIZE-1:0] in_flag;

  logic                        db_req_valid;
  logic                        db_req_ready;
  logic [HASH_SIZE-1:0]        db_req_hash;
  logic [KEY_SIZE-1:0]         db_req_key;
  logic [FLAG_SIZE-1:0]        db_req_op;

  logic                        db_rsp_valid;
  logic [FLAG_SIZE-1:0]        db_rsp_flag;

  logic [NUM_CH-1:0]           out_valid;
  logic [NUM_CH*FLAG_SIZE-1:0] out_flag;

  modport master (
    output in_valid, in_key, in_flag, db_req_ready, db_rsp_valid, db_rsp_flag,
    input  in_ready, db_req_valid, db_req_hash, db_req_key, db_req_op,
           out_valid, out_flag
  );

  modport slave (
    input  in_valid, in_key, in_flag, db_req_ready, db_rsp_valid, db_rsp_flag,
    output in_ready, db_req_valid, db_req_hash, db_req_key, db_req_op,
           out_valid, out_flag
  );

endinterface

// File: rtl/db_req_arb.sv
// db_req_arb: multi-channel key lookup front-end for the key/value DB
// controller. Round-robin arbitration over NUM_CH request streams, fold
// hash of the granted key, one registered DB request per clock, and an
// in-order FIFO of channel ids that steers each DB response back to the
// channel that issued it.
// Optional: define DB_REQ_STATS_EN to add per-channel request/response
// counters on stat_req / stat_rsp.
module db_req_arb #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned KEY_SIZE        = 96,
  parameter int unsigned FLAG_SIZE       = 4,
  parameter int unsigned HASH_SIZE       = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  db_req_arb_if.slave       bus,
  output logic              err_unexp
`ifdef DB_REQ_STATS_EN
  ,
  output logic [NUM_CH*32-1:0] stat_req,
  output logic [NUM_CH*32-1:0] stat_rsp
`endif
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NW    = (KEY_SIZE + HASH_SIZE - 1) / HASH_SIZE;
  localparam int unsigned PAD_W = NW * HASH_SIZE;

  localparam logic [CH_W:0]    NUM_CH_W = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  // arbitration state
  logic [CH_W-1:0]      rr_ptr;
  logic                 grant_valid;
  logic [CH_W-1:0]      grant;
  logic [CH_W:0]        cand_w;
  logic                 can_accept;
  logic                 accept;

  // per-channel unpacked views of the packed input buses
  logic [KEY_SIZE-1:0]  key_arr  [NUM_CH];
  logic [FLAG_SIZE-1:0] flag_arr [NUM_CH];
  logic [KEY_SIZE-1:0]  sel_key;
  logic [FLAG_SIZE-1:0] sel_flag;
  logic [PAD_W-1:0]     padded;
  logic [HASH_SIZE-1:0] sel_hash;

  // request output register
  logic                 req_valid_q;
  logic [KEY_SIZE-1:0]  req_key_q;
  logic [HASH_SIZE-1:0] req_hash_q;
  logic [FLAG_SIZE-1:0] req_op_q;

  // in-flight order FIFO
  logic [CH_W-1:0]      fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [CH_W-1:0]      head;

  // response output register
  logic [NUM_CH-1:0]           out_valid_q;
  logic [NUM_CH*FLAG_SIZE-1:0] out_flag_q;

  // Unpack per-channel key and flag slices.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      key_arr[c]  = bus.in_key[c*KEY_SIZE +: KEY_SIZE];
      flag_arr[c] = bus.in_flag[c*FLAG_SIZE +: FLAG_SIZE];
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand_w      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      // rr_ptr < NUM_CH and i <= NUM_CH, so a single subtract wraps it
      cand_w = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (cand_w >= NUM_CH_W) begin
        cand_w = cand_w - NUM_CH_W;
      end
      if (!grant_valid && bus.in_valid[cand_w[CH_W-1:0]]) begin
        grant_valid = 1'b1;
        grant       = cand_w[CH_W-1:0];
      end
    end
  end

  // Accept gating and per-channel ready; count is taken before any pop.
  always_comb begin
    fifo_empty = (count == '0);
    can_accept = !rst && (!req_valid_q || bus.db_req_ready) && (count < FULL_CNT);
    accept     = can_accept && grant_valid;
    push       = accept;
    pop        = !rst && bus.db_rsp_valid && !fifo_empty;
    head       = fifo_mem[rd_ptr];
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bus.in_ready[c] = accept && (grant == CH_W'(c));
    end
  end

  // Fold hash of the granted key: zero-pad, XOR all HASH_SIZE words.
  always_comb begin
    sel_key  = key_arr[grant];
    sel_flag = flag_arr[grant];
    padded   = PAD_W'(sel_key);
    sel_hash = '0;
    for (int unsigned w = 0; w < NW; w++) begin
      sel_hash = sel_hash ^ padded[w*HASH_SIZE +: HASH_SIZE];
    end
  end

  // Round-robin pointer follows the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= CH_W'(NUM_CH - 1);
    end else if (accept) begin
      rr_ptr <= grant;
    end
  end

  // Request register: reload on accept, hold under backpressure, drain otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_key_q   <= '0;
      req_hash_q  <= '0;
      req_op_q    <= '0;
    end else if (accept) begin
      req_valid_q <= 1'b1;
      req_key_q   <= sel_key;
      req_hash_q  <= sel_hash;
      req_op_q    <= sel_flag;
    end else if (bus.db_req_ready) begin
      req_valid_q <= 1'b0;
    end
  end

  // Order FIFO storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= grant;
    end
  end

  // Order FIFO pointers and occupancy; pointers wrap at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Response steering: one-cycle pulse to the FIFO head channel, flag slice held.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_flag_q  <= '0;
    end else begin
      out_valid_q <= '0;
      if (pop) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (head == CH_W'(c)) begin
            out_valid_q[c]                       <= 1'b1;
            out_flag_q[c*FLAG_SIZE +: FLAG_SIZE] <= bus.db_rsp_flag;
          end
        end
      end
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_unexp <= 1'b0;
    end else if (bus.db_rsp_valid && fifo_empty) begin
      err_unexp <= 1'b1;
    end
  end

`ifdef DB_REQ_STATS_EN
  // Per-channel counters of accepted requests and delivered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req <= '0;
      stat_rsp <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (accept && (grant == CH_W'(c))) begin
          stat_req[c*32 +: 32] <= stat_req[c*32 +: 32] + 32'd1;
        end
        if (pop && (head == CH_W'(c))) begin
          stat_rsp[c*32 +: 32] <= stat_rsp[c*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

  assign bus.db_req_valid = req_valid_q;
  assign bus.db_req_key   = req_key_q;
  assign bus.db_req_hash  = req_hash_q;
  assign bus.db_req_op    = req_op_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_flag     = out_flag_q;

endmodule

// File: tb/tb_db_req_arb.sv
// Directed bench for db_req_arb with NUM_CH=2, MAX_OUTSTANDING=4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_db_req_arb;

  localparam int unsigned NCH = 2;
  localparam int unsigned KS  = 96;
  localparam int unsigned FS  = 4;
  localparam int unsigned HS  = 32;
  localparam int unsigned MO  = 4;

  localparam logic [95:0] KA = 96'h11111111_22222222_44444444; // hash 77777777
  localparam logic [95:0] KB = 96'hA5A5A5A5_0F0F0F0F_00000000; // hash AAAAAAAA
  localparam logic [95:0] KC = 96'h12345678_00000000_FFFFFFFF; // hash EDCBA987
  localparam logic [95:0] KD = 96'hDEADBEEF_DEADBEEF_00000001; // hash 00000001

  logic clk = 1'b0;
  logic rst;
  logic err_unexp;
`ifdef DB_REQ_STATS_EN
  logic [NCH*32-1:0] stat_req;
  logic [NCH*32-1:0] stat_rsp;
`endif

  db_req_arb_if #(.NUM_CH(NCH), .KEY_SIZE(KS), .FLAG_SIZE(FS), .HASH_SIZE(HS)) bus ();

  db_req_arb #(
    .NUM_CH(NCH), .KEY_SIZE(KS), .FLAG_SIZE(FS), .HASH_SIZE(HS), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .err_unexp (err_unexp)
`ifdef DB_REQ_STATS_EN
    ,
    .stat_req  (stat_req),
    .stat_rsp  (stat_rsp)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  iv;
    logic [95:0] k0;
    logic [3:0]  f0;
    logic [95:0] k1;
    logic [3:0]  f1;
    logic        rdy;
    logic        rv;
    logic [3:0]  rf;
    logic [1:0]  e_irdy;
    logic        e_qv;
    logic        dchk;
    logic [95:0] e_key;
    logic [3:0]  e_op;
    logic [31:0] e_hash;
    logic [1:0]  e_ov;
    logic [7:0]  e_of;
    logic        e_err;
  } vec_t;

  vec_t vt [20];

  function automatic logic [31:0] fold_ref(input logic [95:0] k);
    return k[95:64] ^ k[63:32] ^ k[31:0];
  endfunction

  function automatic vec_t mk(
    input logic r, input logic [1:0] iv, input logic [95:0] k0, input logic [3:0] f0,
    input logic [95:0] k1, input logic [3:0] f1, input logic rdy, input logic rv,
    input logic [3:0] rf, input logic [1:0] e_irdy, input logic e_qv, input logic dchk,
    input logic [95:0] e_key, input logic [3:0] e_op, input logic [1:0] e_ov,
    input logic [7:0] e_of, input logic e_err);
    vec_t v;
    v.rst = r; v.iv = iv; v.k0 = k0; v.f0 = f0; v.k1 = k1; v.f1 = f1;
    v.rdy = rdy; v.rv = rv; v.rf = rf; v.e_irdy = e_irdy; v.e_qv = e_qv;
    v.dchk = dchk; v.e_key = e_key; v.e_op = e_op; v.e_hash = fold_ref(e_key);
    v.e_ov = e_ov; v.e_of = e_of; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [1:0] iv, input logic [95:0] k0,
                       input logic [3:0] f0, input logic [95:0] k1, input logic [3:0] f1,
                       input logic rdy, input logic rv, input logic [3:0] rf);
    @(negedge clk);
    rst              = r;
    bus.in_valid     = iv;
    bus.in_key       = {k1, k0};
    bus.in_flag      = {f1, f0};
    bus.db_req_ready = rdy;
    bus.db_rsp_valid = rv;
    bus.db_rsp_flag  = rf;
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end

  initial begin
    logic bad;
    logic [1:0] exp_ov [4];

    // table: reset state, single request, fairness, backpressure, drain
    vt[0]  = mk(1, 2'b11, KA, 1, KC, 5, 1, 0, 0, 2'b00, 0, 1, '0, 0, 2'b00, 8'h00, 0);
    vt[1]  = mk(0, 2'b01, KA, 1, '0, 0, 1, 0, 0, 2'b01, 0, 0, '0, 0, 2'b00, 8'h00, 0);
    vt[2]  = mk(0, 2'b00, KA, 1, '0, 0, 1, 1, 3, 2'b00, 1, 1, KA, 1, 2'b00, 8'h00, 0);
    vt[3]  = mk(0, 2'b00, '0, 0, '0, 0, 1, 0, 0, 2'b00, 0, 0, '0, 0, 2'b01, 8'h03, 0);
    vt[4]  = mk(0, 2'b11, KB, 2, KC, 5, 1, 0, 0, 2'b10, 0, 0, '0, 0, 2'b00, 8'h03, 0);
    vt[5]  = mk(0, 2'b11, KB, 2, KC, 5, 1, 1, 4, 2'b01, 1, 1, KC, 5, 2'b00, 8'h03, 0);
    vt[6]  = mk(0, 2'b11, KB, 2, KC, 5, 1, 1, 1, 2'b10, 1, 1, KB, 2, 2'b10, 8'h43, 0);
    vt[7]  = mk(0, 2'b00, '0, 0, '0, 0, 1, 1, 2, 2'b00, 1, 1, KC, 5, 2'b01, 8'h41, 0);
    vt[8]  = mk(0, 2'b00, '0, 0, '0, 0, 1, 0, 0, 2'b00, 0, 0, '0, 0, 2'b10, 8'h21, 0);
    vt[9]  = mk(0, 2'b01, KD, 6, '0, 0, 0, 0, 0, 2'b01, 0, 0, '0, 0, 2'b00, 8'h21, 0);
    for (int i = 10; i < 15; i++)
      vt[i] = mk(0, 2'b11, KD, 6, KA, 7, 0, 0, 0, 2'b00, 1, 1, KD, 6, 2'b00, 8'h21, 0);
    vt[15] = mk(0, 2'b11, KD, 6, KA, 7, 1, 0, 0, 2'b10, 1, 1, KD, 6, 2'b00, 8'h21, 0);
    vt[16] = mk(0, 2'b00, '0, 0, '0, 0, 1, 0, 0, 2'b00, 1, 1, KA, 7, 2'b00, 8'h21, 0);
    vt[17] = mk(0, 2'b00, '0, 0, '0, 0, 1, 1, 9, 2'b00, 0, 0, '0, 0, 2'b00, 8'h21, 0);
    vt[18] = mk(0, 2'b00, '0, 0, '0, 0, 1, 1, 3, 2'b00, 0, 0, '0, 0, 2'b01, 8'h29, 0);
    vt[19] = mk(0, 2'b00, '0, 0, '0, 0, 1, 0, 0, 2'b00, 0, 0, '0, 0, 2'b10, 8'h39, 0);

    rst = 1'b1;
    bus.in_valid = '0; bus.in_key = '0; bus.in_flag = '0;
    bus.db_req_ready = 1'b0; bus.db_rsp_valid = 1'b0; bus.db_rsp_flag = '0;
    drive(1, 2'b00, '0, 0, '0, 0, 0, 0, 0);
    drive(1, 2'b00, '0, 0, '0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].rst, vt[i].iv, vt[i].k0, vt[i].f0, vt[i].k1, vt[i].f1,
            vt[i].rdy, vt[i].rv, vt[i].rf);
      nvec++;
      bad = (bus.in_ready !== vt[i].e_irdy) || (bus.db_req_valid !== vt[i].e_qv) ||
            (bus.out_valid !== vt[i].e_ov) || (bus.out_flag !== vt[i].e_of) ||
            (err_unexp !== vt[i].e_err);
      if (vt[i].dchk)
        bad = bad || (bus.db_req_key !== vt[i].e_key) || (bus.db_req_op !== vt[i].e_op) ||
              (bus.db_req_hash !== vt[i].e_hash);
      if (bad) begin
        nerr++;
        $display("FAIL vec%0d: got rdy=%b qv=%b key=%h op=%h hash=%h ov=%b of=%h err=%b expected rdy=%b qv=%b key=%h op=%h hash=%h ov=%b of=%h err=%b",
                 i, bus.in_ready, bus.db_req_valid, bus.db_req_key, bus.db_req_op,
                 bus.db_req_hash, bus.out_valid, bus.out_flag, err_unexp,
                 vt[i].e_irdy, vt[i].e_qv, vt[i].e_key, vt[i].e_op, vt[i].e_hash,
                 vt[i].e_ov, vt[i].e_of, vt[i].e_err);
      end
      if (i == 2) check("hash_const", 128'(bus.db_req_hash), 128'(32'h77777777));
    end

    // FIFO full: four ch0 accepts fill the order FIFO
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b01, KA, 1, KC, 5, 1, 0, 0);
      check("fill_rdy", 128'(bus.in_ready), 128'(2'b01));
    end
    drive(0, 2'b11, KA, 1, KC, 5, 1, 0, 0);
    check("full_block", 128'(bus.in_ready), 128'(2'b00));
    drive(0, 2'b11, KA, 1, KC, 5, 1, 1, 5);
    check("full_pop_block", 128'(bus.in_ready), 128'(2'b00));
    drive(0, 2'b11, KA, 1, KC, 5, 1, 0, 0);
    check("after_pop_rdy", 128'(bus.in_ready), 128'(2'b10));
    check("after_pop_ov", 128'(bus.out_valid), 128'(2'b01));
    check("after_pop_of", 128'(bus.out_flag), 128'(8'h35));
    drive(0, 2'b00, KA, 1, KC, 5, 1, 0, 0);
    check("after_pop_key", 128'(bus.db_req_key), 128'(KC));
    check("after_pop_qv", 128'(bus.db_req_valid), 128'(1'b1));
    exp_ov[0] = 2'b01; exp_ov[1] = 2'b01; exp_ov[2] = 2'b01; exp_ov[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b00, '0, 0, '0, 0, 1, 1, 4'(i + 1));
      if (i > 0) check("drain_ov", 128'(bus.out_valid), 128'(exp_ov[i-1]));
    end
    drive(0, 2'b00, '0, 0, '0, 0, 1, 0, 0);
    check("drain_ov", 128'(bus.out_valid), 128'(exp_ov[3]));
    check("drain_of", 128'(bus.out_flag), 128'(8'h43));
    check("drain_err", 128'(err_unexp), 128'(1'b0));

    // unexpected response with empty FIFO
    drive(0, 2'b00, '0, 0, '0, 0, 1, 1, 2);
    drive(0, 2'b00, '0, 0, '0, 0, 1, 0, 0);
    check("unexp_ov", 128'(bus.out_valid), 128'(2'b00));
    check("unexp_err", 128'(err_unexp), 128'(1'b1));
    drive(0, 2'b00, '0, 0, '0, 0, 1, 0, 0);
    check("unexp_sticky", 128'(err_unexp), 128'(1'b1));
    drive(1, 2'b11, KA, 1, KB, 2, 1, 0, 0);
    check("rst_rdy", 128'(bus.in_ready), 128'(2'b00));
    drive(0, 2'b00, '0, 0, '0, 0, 1, 0, 0);
    check("rst_err", 128'(err_unexp), 128'(1'b0));
    check("rst_of", 128'(bus.out_flag), 128'(8'h00));

    // reset with two requests outstanding
    drive(0, 2'b01, KA, 1, KB, 2, 1, 0, 0);
    check("mid_rdy0", 128'(bus.in_ready), 128'(2'b01));
    drive(0, 2'b10, KA, 1, KB, 2, 1, 0, 0);
    check("mid_rdy1", 128'(bus.in_ready), 128'(2'b10));
    drive(1, 2'b11, KA, 1, KB, 2, 1, 0, 0);
    check("mid_rst_rdy", 128'(bus.in_ready), 128'(2'b00));
    check("mid_pre_key", 128'(bus.db_req_key), 128'(KB));
    drive(0, 2'b00, '0, 0, '0, 0, 1, 1, 7);
    check("mid_qv", 128'(bus.db_req_valid), 128'(1'b0));
    check("mid_key", 128'(bus.db_req_key), 128'(96'h0));
    check("mid_ov", 128'(bus.out_valid), 128'(2'b00));
    check("mid_err0", 128'(err_unexp), 128'(1'b0));
`ifdef DB_REQ_STATS_EN
    check("mid_stat_req", 128'(stat_req), 128'(64'h0));
    check("mid_stat_rsp", 128'(stat_rsp), 128'(64'h0));
`endif
    drive(0, 2'b11, KA, 1, KB, 2, 1, 0, 0);
    check("mid_err1", 128'(err_unexp), 128'(1'b1));
    check("mid_ov_drop", 128'(bus.out_valid), 128'(2'b00));
    check("mid_grant0", 128'(bus.in_ready), 128'(2'b01));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
